// File: rtl/dk_audio_pkg.sv
// Shared audio types and helpers for the discrete-sound mixing path.
package dk_audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_ACCUM,
        ST_EMIT
    } mix_state_t;

    localparam int SAMPLE_MAX = 32767;
    localparam int SAMPLE_MIN = -32768;
    localparam int SAT_W      = 48;

    // Clamp a wide signed value into the 16-bit sample range.
    function automatic sample_t sat16(input logic signed [SAT_W-1:0] x);
        logic signed [SAT_W-1:0] maxW;
        logic signed [SAT_W-1:0] minW;
        maxW = SAT_W'(SAMPLE_MAX);
        minW = SAT_W'(SAMPLE_MIN);
        if (x > maxW) begin
            return 16'sh7FFF;
        end else if (x < minW) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

    function automatic logic [15:0] to_offset_bin(input sample_t s);
        return {~s[15], s[14:0]};
    endfunction

endpackage

// File: rtl/dk_mac_lane.sv
// Registered signed multiply-accumulate lane with synchronous clear and enable.
module dk_mac_lane #(
    parameter int A_W   = 16,
    parameter int B_W   = 9,
    parameter int ACC_W = 27
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [A_W+B_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q;

    assign prod  = a_i * b_i;
    assign acc_o = acc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/dk_mix_decimator.sv
// Per-channel gain/mute mixer sharing one MAC lane, followed by a box-car
// decimator that emits saturated signed and offset-binary samples.
module dk_mix_decimator
    import dk_audio_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int OVERSAMPLE = 2,
    parameter int GAIN_W     = 8
) (
    input  logic                       clk,
    input  logic                       I_RST,
    input  logic                       audio_clk_en,
    input  logic [NUM_CH*16-1:0]       in_data,
    input  logic [NUM_CH*GAIN_W-1:0]   ch_gain,
    input  logic [NUM_CH-1:0]          ch_mute,
    output logic signed [15:0]         out,
    output logic [15:0]                O_SOUND_DAT,
    output logic                       out_valid,
    output logic                       overrun
);

    localparam int PROD_W = 16 + GAIN_W + 1;
    localparam int MIX_W  = PROD_W + $clog2(NUM_CH);
    localparam int OS_LOG = $clog2(OVERSAMPLE);
    localparam int DEC_W  = MIX_W - (GAIN_W - 1) + OS_LOG + 1;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PH_W   = (OVERSAMPLE > 1) ? OS_LOG : 1;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
    localparam logic [PH_W-1:0]  LAST_PH = PH_W'(OVERSAMPLE - 1);

    mix_state_t              state_q, state_d;
    logic [IDX_W-1:0]        ch_idx_q, ch_idx_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [DEC_W-1:0] dec_acc_q, dec_acc_d;
    logic signed [DEC_W-1:0] dec_shift;
    sample_t                 out_q, out_d;
    logic [15:0]             snd_q;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    sample_t                 snap_data_q [NUM_CH];
    logic [GAIN_W-1:0]       snap_gain_q [NUM_CH];
    logic [NUM_CH-1:0]       snap_mute_q;

    logic                    snap_load, mac_clr, mac_en;
    sample_t                 lane_a;
    logic signed [GAIN_W:0]  lane_b;
    logic signed [MIX_W-1:0] mix_acc;

    assign out         = out_q;
    assign O_SOUND_DAT = snd_q;
    assign out_valid   = valid_q;
    assign overrun     = overrun_q;

    always_ff @(posedge clk) begin
        if (snap_load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap_data_q[k] <= in_data[16*k +: 16];
                snap_gain_q[k] <= ch_gain[GAIN_W*k +: GAIN_W];
            end
            snap_mute_q <= ch_mute;
        end
    end

    // A muted channel feeds zero so the accumulator still steps once per channel.
    always_comb begin
        lane_a = snap_mute_q[ch_idx_q] ? '0 : snap_data_q[ch_idx_q];
        lane_b = {1'b0, snap_gain_q[ch_idx_q]};
    end

    dk_mac_lane #(
        .A_W   (16),
        .B_W   (GAIN_W + 1),
        .ACC_W (MIX_W)
    ) u_mac (
        .clk_i (clk),
        .rst_i (I_RST),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (lane_a),
        .b_i   (lane_b),
        .acc_o (mix_acc)
    );

    assign dec_shift = dec_acc_q >>> OS_LOG;

    always_comb begin
        state_d   = state_q;
        ch_idx_d  = ch_idx_q;
        phase_d   = phase_q;
        dec_acc_d = dec_acc_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        snap_load = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;

        if (audio_clk_en && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (audio_clk_en) begin
                    snap_load = 1'b1;
                    mac_clr   = 1'b1;
                    ch_idx_d  = '0;
                    state_d   = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en   = 1'b1;
                ch_idx_d = ch_idx_q + 1'b1;
                if (ch_idx_q == LAST_CH) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // The shifted mix always fits DEC_W, so the resize only drops sign copies.
                dec_acc_d = dec_acc_q + DEC_W'(mix_acc >>> (GAIN_W - 1));
                if (phase_q == LAST_PH) begin
                    phase_d = '0;
                    state_d = ST_EMIT;
                end else begin
                    phase_d = phase_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                out_d     = sat16(SAT_W'(dec_shift));
                valid_d   = 1'b1;
                dec_acc_d = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            state_q   <= ST_IDLE;
            ch_idx_q  <= '0;
            phase_q   <= '0;
            dec_acc_q <= '0;
            out_q     <= '0;
            snd_q     <= 16'h8000;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_idx_q  <= ch_idx_d;
            phase_q   <= phase_d;
            dec_acc_q <= dec_acc_d;
            out_q     <= out_d;
            snd_q     <= to_offset_bin(out_d);
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_dk_mix_decimator.sv
// Scoreboard bench for dk_mix_decimator: stimulus pushes expected samples,
// a negedge monitor pops them whenever out_valid is seen.
module tb_dk_mix_decimator;

    logic                clk = 1'b0;
    logic                I_RST;
    logic                audio_clk_en;
    logic [63:0]         in_data;
    logic [31:0]         ch_gain;
    logic [3:0]          ch_mute;
    logic signed [15:0]  out;
    logic [15:0]         O_SOUND_DAT;
    logic                out_valid;
    logic                overrun;

    typedef struct {
        logic [15:0] outv;
        logic [15:0] snd;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lastStrobeCyc = 0;

    localparam logic [31:0] UNITY0 = {8'd0, 8'd0, 8'd0, 8'd128};
    localparam logic [3:0]  ONLY0  = 4'b1110;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dk_mix_decimator #(
        .NUM_CH     (4),
        .OVERSAMPLE (2),
        .GAIN_W     (8)
    ) dut (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .in_data      (in_data),
        .ch_gain      (ch_gain),
        .ch_mute      (ch_mute),
        .out          (out),
        .O_SOUND_DAT  (O_SOUND_DAT),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

    function automatic logic [63:0] pack4(input logic signed [15:0] a, input logic signed [15:0] b,
                                          input logic signed [15:0] c, input logic signed [15:0] d);
        return {d, c, b, a};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs are scrambled right after the strobe so only the snapshot can be used.
    task automatic strobe(input logic [63:0] data, input logic [31:0] gain, input logic [3:0] mute);
        @(negedge clk);
        in_data      = data;
        ch_gain      = gain;
        ch_mute      = mute;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en  = 1'b0;
        in_data       = ~data;
        lastStrobeCyc = cyc;
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic [31:0] gain, input logic [3:0] mute,
                                 input logic expectOut, input logic [15:0] expOut, input logic [15:0] expSnd);
        exp_t e;
        strobe(data, gain, mute);
        if (expectOut) begin
            e.outv = expOut;
            e.snd  = expSnd;
            e.cyc  = lastStrobeCyc + 6;
            expQ.push_back(e);
        end
        repeat (10) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            exp_t e;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedValid: out_valid at cycle %0d, expected none", cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput("out", {16'd0, out}, {16'd0, e.outv});
                checkOutput("soundDat", {16'd0, O_SOUND_DAT}, {16'd0, e.snd});
                checkOutput("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        I_RST        = 1'b1;
        audio_clk_en = 1'b0;
        in_data      = '0;
        ch_gain      = '0;
        ch_mute      = '0;
        repeat (3) @(negedge clk);
        I_RST = 1'b0;
        checkOutput("resetOut", {16'd0, out}, 32'h0);
        checkOutput("resetSnd", {16'd0, O_SOUND_DAT}, 32'h8000);
        checkOutput("resetValid", {31'd0, out_valid}, 32'h0);
        checkOutput("resetOverrun", {31'd0, overrun}, 32'h0);

        $display("[TB] single channel, unity gain");
        applyStimulus(pack4(1000, 0, 0, 0), UNITY0, ONLY0, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(1000, 0, 0, 0), UNITY0, ONLY0, 1'b1, 16'd1000, 16'h83E8);
        applyStimulus(pack4(1000, 0, 0, 0), UNITY0, ONLY0, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(1000, 0, 0, 0), UNITY0, ONLY0, 1'b1, 16'd1000, 16'h83E8);

        $display("[TB] gain and truncation");
        applyStimulus(pack4(1000, 0, 0, 0), {24'd0, 8'd64}, ONLY0, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(1000, 0, 0, 0), {24'd0, 8'd64}, ONLY0, 1'b1, 16'd500, 16'h81F4);
        applyStimulus(pack4(1000, 0, 0, 0), {24'd0, 8'd255}, ONLY0, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(1000, 0, 0, 0), {24'd0, 8'd255}, ONLY0, 1'b1, 16'd1992, 16'h87C8);
        applyStimulus(pack4(1000, 0, 0, 0), {24'd0, 8'd0}, ONLY0, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(1000, 0, 0, 0), {24'd0, 8'd0}, ONLY0, 1'b1, 16'd0, 16'h8000);

        $display("[TB] mixed channels with a muted non-zero voice");
        applyStimulus(pack4(1000, -400, 50, 7777), {8'd128, 8'd255, 8'd64, 8'd128}, 4'b1000, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(1000, -400, 50, 7777), {8'd128, 8'd255, 8'd64, 8'd128}, 4'b1000, 1'b1, 16'd899, 16'h8383);

        $display("[TB] saturation");
        applyStimulus(pack4(30000, 30000, 30000, 30000), {4{8'd128}}, 4'b0000, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(30000, 30000, 30000, 30000), {4{8'd128}}, 4'b0000, 1'b1, 16'h7FFF, 16'hFFFF);
        applyStimulus(pack4(-30000, -30000, -30000, -30000), {4{8'd128}}, 4'b0000, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(-30000, -30000, -30000, -30000), {4{8'd128}}, 4'b0000, 1'b1, 16'h8000, 16'h0000);

        $display("[TB] decimation averaging");
        applyStimulus(pack4(100, 0, 0, 0), UNITY0, ONLY0, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(301, 0, 0, 0), UNITY0, ONLY0, 1'b1, 16'd200, 16'h80C8);
        applyStimulus(pack4(-3, 0, 0, 0), UNITY0, ONLY0, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(-2, 0, 0, 0), UNITY0, ONLY0, 1'b1, 16'hFFFD, 16'h7FFD);

        $display("[TB] overrun");
        checkOutput("overrunClear", {31'd0, overrun}, 32'h0);
        strobe(pack4(1000, 0, 0, 0), UNITY0, ONLY0);
        @(negedge clk);
        @(negedge clk);
        in_data      = pack4(-20000, -20000, -20000, -20000);
        ch_gain      = {4{8'd128}};
        ch_mute      = 4'b0000;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (7) @(negedge clk);
        applyStimulus(pack4(1000, 0, 0, 0), UNITY0, ONLY0, 1'b1, 16'd1000, 16'h83E8);
        checkOutput("overrunSet", {31'd0, overrun}, 32'h1);

        $display("[TB] reset mid-MAC");
        applyStimulus(pack4(5000, 0, 0, 0), UNITY0, ONLY0, 1'b0, 16'h0, 16'h0);
        checkOutput("overrunSticky", {31'd0, overrun}, 32'h1);
        strobe(pack4(7000, 0, 0, 0), UNITY0, ONLY0);
        @(negedge clk);
        I_RST = 1'b1;
        repeat (2) @(negedge clk);
        I_RST = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midResetOut", {16'd0, out}, 32'h0);
        checkOutput("midResetSnd", {16'd0, O_SOUND_DAT}, 32'h8000);
        checkOutput("midResetValid", {31'd0, out_valid}, 32'h0);
        checkOutput("midResetOverrun", {31'd0, overrun}, 32'h0);
        applyStimulus(pack4(1000, 0, 0, 0), UNITY0, ONLY0, 1'b0, 16'h0, 16'h0);
        applyStimulus(pack4(1000, 0, 0, 0), UNITY0, ONLY0, 1'b1, 16'd1000, 16'h83E8);

        for (int i = 0; i < 200 && expQ.size() > 0; i++) @(negedge clk);
        while (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missingValid: no out_valid seen, expected at cycle %0d", e.cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dk_mix_decimator.md
Name: dk_mix_decimator

Overview:
- Downstream consumer of the discrete sound voices (dk_walk and its siblings).
- Takes NUM_CH signed 16-bit voice outputs, updated at the oversampled audio rate marked by audio_clk_en.
- Applies per-channel gain and mute, then mixes the channels with one time-multiplexed multiplier.
- Box-car decimates by OVERSAMPLE and emits a saturated 48 kHz sample, both signed and offset-binary (O_SOUND_DAT) for the core audio path.

Parameters:
- NUM_CH, 4, number of voice inputs (>=1).
- OVERSAMPLE, 2, decimation ratio; power of two, >=1.
- GAIN_W, 8, unsigned gain width; unity gain = 2**(GAIN_W-1).

Ports:
- clk  in  1  system clock.
- I_RST  in  1  reset; synchronous, active-high.
- audio_clk_en  in  1  one-cycle strobe per oversampled sample.
- in_data  in  NUM_CH*16  signed voice samples; channel k at bits [16k+15:16k].
- ch_gain  in  NUM_CH*GAIN_W  unsigned per-channel gain; channel k at bits [GAIN_W*k+GAIN_W-1:GAIN_W*k].
- ch_mute  in  NUM_CH  1 = channel contributes 0.
- out  out  16  signed mixed, decimated sample.
- O_SOUND_DAT  out  16  out + 0x8000 (offset binary).
- out_valid  out  1  one-cycle pulse when out/O_SOUND_DAT update.
- overrun  out  1  sticky: audio_clk_en arrived while busy.

Behaviour:
- Reset (I_RST high at a clk edge): state=IDLE, out=0, O_SOUND_DAT=0x8000, out_valid=0, overrun=0, all accumulators and the phase counter = 0. Applies from any state; an in-flight mix is discarded.
- FSM states: IDLE, MAC, ACCUM, EMIT.
- IDLE:
  - audio_clk_en=1 at edge t: snapshot in_data, ch_gain and ch_mute into registers; clear mix_acc and ch_idx; go to MAC.
- MAC: one channel per cycle, edges t+1 .. t+NUM_CH.
  - mix_acc += snap_data[ch_idx] * signed({1'b0, snap_gain[ch_idx]}), or += 0 when the channel is muted.
  - ch_idx increments; after channel NUM_CH-1, go to ACCUM.
- ACCUM, edge t+NUM_CH+1:
  - dec_acc += (mix_acc >>> (GAIN_W-1)). This is an arithmetic shift (truncation toward -inf); no saturation at this point.
  - If phase == OVERSAMPLE-1: phase=0, go to EMIT. Otherwise phase++ and go to IDLE.
- EMIT, edge t+NUM_CH+2:
  - val = dec_acc >>> log2(OVERSAMPLE), saturated to [-32768, 32767].
  - out = val; O_SOUND_DAT = val ^ 0x8000; out_valid=1 for exactly this cycle; dec_acc=0; go to IDLE.
- Latency: from the audio_clk_en strobe that completes a decimation group to out_valid = NUM_CH+2 clk.
- Widths:
  - product = 16+GAIN_W+1 bits.
  - mix_acc = product + clog2(NUM_CH) bits.
  - dec_acc = mix_acc - (GAIN_W-1) + clog2(OVERSAMPLE) + 1 bits.
  - No intermediate overflow is permitted.
- audio_clk_en while state != IDLE: strobe ignored (no snapshot, phase unchanged); overrun=1 until reset.
- Minimum legal strobe spacing is NUM_CH+3 clk. The codebase uses 12 clk per sample, which is sufficient for NUM_CH<=9.
- out and O_SOUND_DAT hold between out_valid pulses.
- in_data may change at any time; only the snapshot is used.

Decomposition:
- Package dk_audio_pkg holds:
  - typedef sample_t (logic signed [15:0]);
  - constants SAMPLE_MAX=32767 and SAMPLE_MIN=-32768;
  - function sat16 (wide signed -> sample_t);
  - function to_offset_bin (sample_t -> unsigned 16).
- One sub-module, dk_mac_lane: registered multiply-accumulate with clear and enable. The FSM, snapshot registers and decimator stay in the top level.

Test Plan (NUM_CH=4, OVERSAMPLE=2, GAIN_W=8):
- Reset: assert I_RST 2 clk mid-MAC -> out=0, O_SOUND_DAT=0x8000, out_valid=0, overrun=0; the next strobe starts a fresh group (phase 0).
- Single channel: ch0=1000, gain0=128, ch1..3 muted, strobes every 12 clk -> out_valid every 24 clk, 6 clk after each 2nd strobe; out=1000, O_SOUND_DAT=0x83E8.
- Gain and truncation:
  - ch0=1000, gain0=64 -> out=500;
  - gain0=255 -> out=1992;
  - gain0=0 -> out=0.
- Saturation:
  - all four channels 30000, gain 128 -> out=32767, O_SOUND_DAT=0xFFFF;
  - all four -30000 -> out=-32768, O_SOUND_DAT=0x0000.
- Decimation averaging:
  - ch0 sequence 100, 301 (unity gain) -> out=200;
  - sequence -3, -2 -> out=-3 (floor).
- Overrun: two strobes 3 clk apart -> second ignored, overrun=1 and sticky; the group completes on the next legal strobe with correct data; I_RST clears overrun.
